// File: rtl/clock_pkg.sv
// clock_pkg: mode encodings, BCD limits and debounce default shared by time_keeper and its button filters
package clock_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_t;
   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam int DEBOUNCE_DEF = 20;
   // Two-digit BCD increment that wraps to 00 after lim.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      return (v == lim) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button, filters it on 1 kHz ticks and pulses once per accepted press
module btn_debounce import clock_pkg::*; #(
   parameter int DEBOUNCE_CNT = DEBOUNCE_DEF
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   logic [1:0] r_sync;
   logic r_stable;
   logic r_press;
   logic [CW-1:0] r_cnt;
   logic w_diff;
   logic w_flip;
   assign w_diff = i_tick && (r_sync[1] != r_stable);
   assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CNT - 1));
   always_ff @(posedge clk_50MHz or negedge rst_n)
      if (!rst_n) begin
         r_sync <= '0;
         r_stable <= 1'b0;
         r_cnt <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         if (i_tick) r_cnt <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
         if (w_flip) r_stable <= ~r_stable;
         r_press <= w_flip && !r_stable;
      end
   assign o_press = r_press;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD 24-hour clock advanced by a synchronised 1 Hz input, set via debounced mode/inc buttons
module time_keeper import clock_pkg::*; #(
   parameter int DEBOUNCE_CNT = DEBOUNCE_DEF
) (
   input  logic       clk_50MHz,
   input  logic       rst_n,
   input  logic       clk_1Hz_in,
   input  logic       clk_1kHz_in,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       blink
);
   logic [2:0] r_hz_sync;
   logic [2:0] r_khz_sync;
   logic [7:0] r_hour;
   logic [7:0] r_min;
   logic [7:0] r_sec;
   logic r_sec_tick;
   logic r_blink;
   mode_t r_mode;
   mode_t w_mode_next;
   logic w_hz_tick;
   logic w_khz_tick;
   logic w_mode_press;
   logic w_inc_press;
   logic w_set_h;
   logic w_set_m;
   logic w_clr_sec;
   logic w_run_tick;
   logic w_blink_d;
   // Two sync flops, third flop only for rising-edge detection.
   always_ff @(posedge clk_50MHz or negedge rst_n)
      if (!rst_n) begin
         r_hz_sync <= '0;
         r_khz_sync <= '0;
      end else begin
         r_hz_sync <= {r_hz_sync[1:0], clk_1Hz_in};
         r_khz_sync <= {r_khz_sync[1:0], clk_1kHz_in};
      end
   assign w_hz_tick = r_hz_sync[1] && !r_hz_sync[2];
   assign w_khz_tick = r_khz_sync[1] && !r_khz_sync[2];
   btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_mode (
      .clk_50MHz(clk_50MHz), .rst_n(rst_n), .i_tick(w_khz_tick), .i_btn(btn_mode), .o_press(w_mode_press)
   );
   btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_inc (
      .clk_50MHz(clk_50MHz), .rst_n(rst_n), .i_tick(w_khz_tick), .i_btn(btn_inc), .o_press(w_inc_press)
   );
   always_ff @(posedge clk_50MHz or negedge rst_n)
      if (!rst_n) r_mode <= RUN;
      else r_mode <= w_mode_next;
   always_comb
      w_mode_next = !w_mode_press ? r_mode :
                    (r_mode == RUN) ? SET_HOUR :
                    (r_mode == SET_HOUR) ? SET_MIN : RUN;
   // A mode press in the same cycle swallows any inc press.
   always_comb begin
      w_set_h = (r_mode == SET_HOUR) && w_inc_press && !w_mode_press;
      w_set_m = (r_mode == SET_MIN) && w_inc_press && !w_mode_press;
      w_clr_sec = (r_mode == SET_MIN) && w_mode_press;
      w_run_tick = (r_mode == RUN) && w_hz_tick;
      w_blink_d = (w_mode_next != RUN) && r_hz_sync[1];
   end
   always_ff @(posedge clk_50MHz or negedge rst_n)
      if (!rst_n) begin
         r_hour <= '0;
         r_min <= '0;
         r_sec <= '0;
         r_sec_tick <= 1'b0;
         r_blink <= 1'b0;
      end else begin
         r_sec_tick <= w_hz_tick;
         r_blink <= w_blink_d;
         if (w_clr_sec) r_sec <= '0;
         else if (w_run_tick) r_sec <= bcd_inc(r_sec, MIN_MAX);
         if ((w_run_tick && r_sec == MIN_MAX) || w_set_m) r_min <= bcd_inc(r_min, MIN_MAX);
         if ((w_run_tick && r_sec == MIN_MAX && r_min == MIN_MAX) || w_set_h) r_hour <= bcd_inc(r_hour, HOUR_MAX);
      end
   assign hour_bcd = r_hour;
   assign min_bcd = r_min;
   assign sec_bcd = r_sec;
   assign mode = r_mode;
   assign sec_tick = r_sec_tick;
   assign blink = r_blink;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed stimulus against a seconds-of-day model of the clock, checked every settled cycle
module tb_time_keeper;
   logic clk_50MHz = 0, rst_n = 0, clk_1Hz_in = 0, clk_1kHz_in = 0, btn_mode = 0, btn_inc = 0;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic [1:0] mode;
   logic sec_tick, blink;
   int n_chk = 0, n_err = 0, n_ticks = 0, m_ticks = 0;
   int m_h = 0, m_m = 0, m_s = 0, m_mode = 0;
   bit chk_en = 0;
   logic prev_tick = 0;

   time_keeper dut (
      .clk_50MHz(clk_50MHz), .rst_n(rst_n), .clk_1Hz_in(clk_1Hz_in), .clk_1kHz_in(clk_1kHz_in),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
      .sec_bcd(sec_bcd), .mode(mode), .sec_tick(sec_tick), .blink(blink)
   );

   initial forever #10 clk_50MHz = ~clk_50MHz;
   // Scaled 1 kHz: one rising edge every 4 system cycles.
   initial forever begin
      repeat (2) @(negedge clk_50MHz);
      clk_1kHz_in = ~clk_1kHz_in;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   task automatic m_second();
      int t;
      m_ticks++;
      if (m_mode == 0) begin
         t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
         m_h = t / 3600;
         m_m = (t / 60) % 60;
         m_s = t % 60;
      end
   endtask

   task automatic m_press(input bit pm, input bit pi);
      if (pm) begin
         m_mode = (m_mode + 1) % 3;
         if (m_mode == 0) m_s = 0;
      end else if (pi && m_mode == 1) m_h = (m_h + 1) % 24;
      else if (pi && m_mode == 2) m_m = (m_m + 1) % 60;
   endtask

   always @(posedge clk_50MHz) begin
      #1;
      if (chk_en) begin
         chk("hour", hour_bcd, bcd(m_h));
         chk("min", min_bcd, bcd(m_m));
         chk("sec", sec_bcd, bcd(m_s));
         chk("mode", mode, m_mode);
         chk("blink", blink, (m_mode != 0) && clk_1Hz_in);
         chk("sec_tick_idle", sec_tick, 0);
      end
   end

   always @(posedge clk_50MHz) begin
      #1;
      if (sec_tick) begin
         n_ticks++;
         chk("sec_tick_width", prev_tick, 0);
      end
      prev_tick = sec_tick;
   end

   task automatic tick();
      chk_en = 0;
      @(negedge clk_50MHz) clk_1Hz_in = 1;
      repeat (2) @(negedge clk_50MHz);
      clk_1Hz_in = 0;
      repeat (2) @(negedge clk_50MHz);
      m_second();
      chk_en = 1;
      @(negedge clk_50MHz);
   endtask

   task automatic release_and_settle(input bit pm, input bit pi);
      btn_mode = 0;
      btn_inc = 0;
      repeat (100) @(negedge clk_50MHz);
      m_press(pm, pi);
      chk_en = 1;
      @(negedge clk_50MHz);
   endtask

   task automatic press(input bit pm, input bit pi);
      chk_en = 0;
      @(negedge clk_50MHz);
      btn_mode = pm;
      btn_inc = pi;
      repeat (100) @(negedge clk_50MHz);
      release_and_settle(pm, pi);
   endtask

   task automatic bounce_inc();
      int seg[4];
      seg = '{8, 4, 12, 8};
      chk_en = 0;
      @(negedge clk_50MHz);
      for (int k = 0; k < 4; k++) begin
         btn_inc = ~btn_inc;
         repeat (seg[k]) @(negedge clk_50MHz);
      end
      btn_inc = 1;
      repeat (100) @(negedge clk_50MHz);
      release_and_settle(0, 1);
   endtask

   task automatic chk_time(input string nm, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      chk({nm, "_h"}, hour_bcd, h);
      chk({nm, "_m"}, min_bcd, m);
      chk({nm, "_s"}, sec_bcd, s);
   endtask

   initial begin
      repeat (3) @(negedge clk_50MHz);
      chk_time("reset", 8'h00, 8'h00, 8'h00);
      chk("reset_mode", mode, 0);
      chk("reset_tick", sec_tick, 0);
      chk("reset_blink", blink, 0);
      rst_n = 1;
      @(negedge clk_50MHz) clk_1Hz_in = 1;
      repeat (2) @(posedge clk_50MHz);
      #1 chk("lat_p2_tick", sec_tick, 0);
      chk("lat_p2_sec", sec_bcd, 8'h00);
      @(posedge clk_50MHz);
      #1 chk("lat_p3_tick", sec_tick, 1);
      chk("lat_p3_sec", sec_bcd, 8'h01);
      chk("blink_run", blink, 0);
      @(posedge clk_50MHz);
      #1 chk("lat_p4_tick", sec_tick, 0);
      @(negedge clk_50MHz) clk_1Hz_in = 0;
      repeat (3) @(negedge clk_50MHz);
      m_second();
      chk_en = 1;
      @(negedge clk_50MHz);
      repeat (3699) tick();
      chk_time("run_3700", 8'h01, 8'h01, 8'h40);
      chk("ticks_3700", n_ticks, 3700);
      press(1, 0);
      chk("mode_set_hour", mode, 1);
      chk_en = 0;
      @(negedge clk_50MHz) clk_1Hz_in = 1;
      repeat (4) @(negedge clk_50MHz);
      m_second();
      chk_en = 1;
      repeat (3) @(negedge clk_50MHz);
      chk("blink_set", blink, 1);
      chk_en = 0;
      clk_1Hz_in = 0;
      repeat (3) @(negedge clk_50MHz);
      chk_en = 1;
      @(negedge clk_50MHz);
      chk_time("set_no_advance", 8'h01, 8'h01, 8'h40);
      repeat (8) press(0, 1);
      chk("hour_09", hour_bcd, 8'h09);
      bounce_inc();
      chk("bounce_hour_10", hour_bcd, 8'h10);
      repeat (2) press(0, 1);
      press(1, 0);
      repeat (33) press(0, 1);
      press(1, 0);
      chk_time("set_1234", 8'h12, 8'h34, 8'h00);
      repeat (56) tick();
      chk_time("run_123456", 8'h12, 8'h34, 8'h56);
      press(1, 0);
      chk("m3_mode1", mode, 1);
      press(1, 0);
      chk("m3_mode2", mode, 2);
      press(1, 0);
      chk("m3_mode0", mode, 0);
      chk_time("m3_time", 8'h12, 8'h34, 8'h00);
      press(1, 0);
      repeat (11) press(0, 1);
      press(1, 0);
      repeat (25) press(0, 1);
      tick();
      chk_time("preload_set", 8'h23, 8'h59, 8'h00);
      press(1, 0);
      repeat (58) tick();
      chk_time("pre_58", 8'h23, 8'h59, 8'h58);
      tick();
      chk_time("roll_59", 8'h23, 8'h59, 8'h59);
      tick();
      chk_time("roll_00", 8'h00, 8'h00, 8'h00);
      press(0, 1);
      chk_time("run_inc_ignored", 8'h00, 8'h00, 8'h00);
      press(1, 0);
      press(0, 1);
      press(1, 1);
      chk("same_cycle_mode", mode, 2);
      chk("same_cycle_hour", hour_bcd, 8'h01);
      chk_en = 0;
      @(negedge clk_50MHz) btn_mode = 1;
      repeat (60) @(negedge clk_50MHz);
      rst_n = 0;
      repeat (2) @(negedge clk_50MHz);
      chk_time("mid_rst", 8'h00, 8'h00, 8'h00);
      chk("mid_rst_mode", mode, 0);
      chk("mid_rst_blink", blink, 0);
      repeat (2) @(negedge clk_50MHz);
      rst_n = 1;
      m_h = 0;
      m_m = 0;
      m_s = 0;
      m_mode = 0;
      repeat (40) @(negedge clk_50MHz);
      btn_mode = 0;
      repeat (100) @(negedge clk_50MHz);
      chk_en = 1;
      repeat (5) @(negedge clk_50MHz);
      chk("post_rst_mode", mode, 0);
      press(1, 0);
      chk("post_rst_press", mode, 1);
      chk("ticks_total", n_ticks, m_ticks);
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 20, is the number of consecutive equal 1 kHz samples needed to accept a button level change.
REQ-002 clk_50MHz  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clk_1Hz_in  input  1  divided 1 Hz square wave, asynchronous to the block's sequential logic, SHALL be synchronised before use.
REQ-005 clk_1kHz_in  input  1  divided 1 kHz square wave, same treatment as clk_1Hz_in.
REQ-006 btn_mode  input  1  raw mode push-button, active-high, bouncing.
REQ-007 btn_inc  input  1  raw increment push-button, active-high, bouncing.
REQ-008 hour_bcd  output  8  hours as two BCD digits, 00-23.
REQ-009 min_bcd  output  8  minutes as two BCD digits, 00-59.
REQ-010 sec_bcd  output  8  seconds as two BCD digits, 00-59.
REQ-011 mode  output  2  current mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
REQ-012 sec_tick  output  1  one-cycle pulse on each accepted 1 Hz rising edge.
REQ-013 blink  output  1  synchronised 1 Hz level while in a SET mode, 0 in RUN.

Function
REQ-014 Each divided input SHALL pass through a 2-flop synchroniser plus a third edge-detect flop; a rising edge SHALL produce a single-cycle tick 3 clk_50MHz cycles after the input rise was first sampled.
REQ-015 In RUN, each 1 Hz tick SHALL increment sec; 59->00 carries to min; min 59->00 carries to hour; hour 23->00; 23:59:59 -> 00:00:00 in a single cycle.
REQ-016 sec_tick SHALL pulse on every 1 Hz tick in all modes; time SHALL NOT advance in SET_HOUR or SET_MIN.
REQ-017 Debounce: raw buttons sampled only on 1 kHz ticks; a per-button counter SHALL count consecutive samples differing from the stable level, resetting to 0 on any sample equal to it; at DEBOUNCE_CNT the stable level SHALL flip and the counter clear.
REQ-018 A stable 0->1 transition SHALL produce exactly one single-cycle press pulse; release produces none.
REQ-019 Mode FSM: RUN -mode press-> SET_HOUR -mode press-> SET_MIN -mode press-> RUN; no other transitions.
REQ-020 On the SET_MIN->RUN transition sec SHALL be cleared to 00 in the same cycle the mode changes.
REQ-021 In SET_HOUR an inc press SHALL increment hour, 23->00, no carry; in SET_MIN it SHALL increment min, 59->00, no carry into hour.
REQ-022 In RUN inc presses SHALL be ignored.
REQ-023 Mode and inc press pulses in the same cycle: mode change wins, inc dropped.
REQ-024 All BCD digits SHALL remain legal BCD at all times; low digit 9 rolls to 0 with high-digit increment.
REQ-025 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-026 While rst_n=0: hour/min/sec = 00, mode=RUN, sec_tick=0, blink=0, all synchroniser flops 0, debounce stable levels 0, counters 0.
REQ-027 Reset asserted mid-operation (mid-debounce, mid-set) SHALL abort immediately; after release no press or tick SHALL be generated from pre-reset history.

Structure
REQ-028 Shared package clock_pkg SHALL hold mode encodings, BCD limits (23, 59) and the DEBOUNCE_CNT default.
REQ-029 Sub-module btn_debounce (synchroniser, 1 kHz-gated counter, press pulse) SHALL be instantiated once per button.

Verification
REQ-030 Reset released, 86400 1 Hz edges -> time returns to 00:00:00, sec_tick count 86400.
REQ-031 Preload 23:59:58 via SET, two 1 Hz edges -> 23:59:59 then 00:00:00.
REQ-032 btn_inc bounce of 5 toggles within 10 ms then held 25 ms, in SET_HOUR from 09 -> hour 10, exactly one increment.
REQ-033 Mode presses x3 from RUN at 12:34:56 -> modes 1,2,0; sec 00 on return; hour/min unchanged.
REQ-034 mode and inc debounced in same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged.
REQ-035 rst_n pulsed low mid-debounce in SET_MIN -> 00:00:00, RUN, no spurious press after release.
